// File: rtl/fp_mul_round_pack.sv
// Back end of a binary32 multiplier: normalizes a 48-bit significand product,
// rounds to nearest-even and packs sign/exponent/fraction, with overflow/underflow flags.
module fp_mul_round_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp_sum,
  input  logic [47:0] in_mant,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf,
  output logic        out_unf
);

  localparam logic signed [10:0] BIAS    = 11'sd127;
  localparam logic signed [10:0] EXP_MAX = 11'sd255;

  typedef struct packed {
    logic               sign;
    logic               zero;
    logic signed [10:0] exp;
    logic [22:0]        frac;
    logic               guard;
    logic               sticky;
  } norm_t;

  norm_t s1_d;
  norm_t s1_q;
  logic  s1_valid;
  logic  s2_valid;
  logic  s2_ready;
  logic  s1_adv;
  logic  in_fire;

  // Handshake: S2 frees up when empty or drained; S1 can refill as it empties.
  assign s2_ready  = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_ready;
  assign in_ready  = !rst && (!s1_valid || s1_adv);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // S1: unbias the exponent and normalize the product to 1.f form.
  always_comb begin
    // NOTE: every field gets a default first so no path through the block can infer a latch.
    s1_d        = '0;
    s1_d.sign   = in_sign;
    s1_d.zero   = in_zero;
    s1_d.exp    = signed'({2'b00, in_exp_sum}) - BIAS;
    if (in_mant[47]) begin
      s1_d.exp    = s1_d.exp + 11'sd1;
      s1_d.frac   = in_mant[46:24];
      s1_d.guard  = in_mant[23];
      s1_d.sticky = |in_mant[22:0];
    end else begin
      s1_d.frac   = in_mant[45:23];
      s1_d.guard  = in_mant[22];
      s1_d.sticky = |in_mant[21:0];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: the S1 payload is not reset; it is only observed when s1_valid is set.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_q <= s1_d;
    end
  end

  // S2: round to nearest-even, then classify against the exponent range.
  logic               round_up;
  logic               carry;
  logic [22:0]        frac_r;
  logic signed [10:0] exp_r;
  logic [31:0]        result_d;
  logic               ovf_d;
  logic               unf_d;

  always_comb begin
    round_up        = s1_q.guard && (s1_q.sticky || s1_q.frac[0]);
    {carry, frac_r} = {1'b0, s1_q.frac} + 24'(round_up);
    exp_r           = s1_q.exp + signed'({10'b0, carry});
    result_d        = {s1_q.sign, exp_r[7:0], frac_r};
    ovf_d           = 1'b0;
    unf_d           = 1'b0;
    if (s1_q.zero) begin
      result_d = {s1_q.sign, 31'b0};
    end else if (exp_r >= EXP_MAX) begin
      result_d = {s1_q.sign, 8'hFF, 23'b0};
      ovf_d    = 1'b1;
    end else if (exp_r <= 11'sd0) begin
      result_d = {s1_q.sign, 31'b0};
      unf_d    = 1'b1;
    end
  end

  // Result registers load only when S2 can accept, which holds them during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_unf    <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= result_d;
        out_ovf    <= ovf_d;
        out_unf    <= unf_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Directed bench for fp_mul_round_pack: vector table plus backpressure and
// mid-operation reset sequences.
module tb_fp_mul_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp_sum;
  logic [47:0] in_mant;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  always #5 clk = ~clk;

  fp_mul_round_pack dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp_sum (in_exp_sum),
    .in_mant    (in_mant),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf)
  );

  typedef struct {
    string       name;
    logic        sign;
    logic [8:0]  exp_sum;
    logic [47:0] mant;
    logic        zero;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input string n, input logic s, input logic [8:0] e, input logic [47:0] m,
                     input logic z, input logic [31:0] r, input logic o, input logic u);
    vec_t v;
    v.name = n; v.sign = s; v.exp_sum = e; v.mant = m; v.zero = z;
    v.result = r; v.ovf = o; v.unf = u;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; in_sign = 1'b0; in_exp_sum = '0; in_mant = '0; in_zero = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid = 1'b1; in_sign = v.sign; in_exp_sum = v.exp_sum; in_mant = v.mant; in_zero = v.zero;
  endtask

  // One isolated beat with out_ready=1: accepted, invisible for a cycle, valid on the second.
  task automatic apply_one(input vec_t v);
    @(negedge clk); drive_vec(v); #1;
    check({v.name, "_in_ready"}, in_ready, 1);
    @(negedge clk); drive_idle(); #1;
    check({v.name, "_early"}, out_valid, 0);
    @(negedge clk); #1;
    check({v.name, "_valid"}, out_valid, 1);
    check({v.name, "_result"}, out_result, v.result);
    check({v.name, "_flags"}, {out_ovf, out_unf}, {v.ovf, v.unf});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got_r[$];
    logic [1:0]  got_f[$];
    logic [31:0] held;
    int          idx;
    int          stalls;

    //   name             sign exp  mant               zero result        ovf unf
    add("x1p5_x2",        0, 255, 48'h6000_0000_0000, 0, 32'h4040_0000, 0, 0);
    add("norm_shift",     0, 254, 48'h9000_0000_0000, 0, 32'h4010_0000, 0, 0);
    add("tie_carry",      0, 254, 48'h7FFF_FFC0_0000, 0, 32'h4000_0000, 0, 0);
    add("ovf_neg",        1, 400, 48'h8000_0000_0000, 0, 32'hFF80_0000, 1, 0);
    add("unf",            0, 100, 48'h4000_0000_0000, 0, 32'h0000_0000, 0, 1);
    add("zero_neg",       1, 400, 48'h8000_0000_0000, 1, 32'h8000_0000, 0, 0);
    add("max_norm",       0, 381, 48'h4000_0000_0000, 0, 32'h7F00_0000, 0, 0);
    add("exp_255",        0, 382, 48'h4000_0000_0000, 0, 32'h7F80_0000, 1, 0);
    add("round_to_ovf",   0, 381, 48'h7FFF_FFC0_0000, 0, 32'h7F80_0000, 1, 0);
    add("min_norm",       0, 128, 48'h4000_0000_0000, 0, 32'h0080_0000, 0, 0);
    add("exp_0_neg",      1, 127, 48'h4000_0000_0000, 0, 32'h8000_0000, 0, 1);
    add("round_from_unf", 0, 127, 48'h7FFF_FFC0_0000, 0, 32'h0080_0000, 0, 0);
    add("tie_even",       0, 254, 48'h4000_0040_0000, 0, 32'h3F80_0000, 0, 0);
    add("above_half",     0, 254, 48'h4000_0060_0000, 0, 32'h3F80_0001, 0, 0);
    add("tie_odd",        0, 254, 48'h4000_00C0_0000, 0, 32'h3F80_0002, 0, 0);
    add("below_half",     0, 254, 48'h4000_0020_0000, 0, 32'h3F80_0000, 0, 0);
    add("hi_path_round",  1, 254, 48'h8000_0180_0000, 0, 32'hC000_0002, 0, 0);
    add("zero_small",     0,   0, 48'h0000_0000_0000, 1, 32'h0000_0000, 0, 0);

    // Reset state
    rst = 1'b1; out_ready = 1'b1; drive_idle();
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_flags", {out_ovf, out_unf}, 0);
    rst = 1'b0; #1;
    check("post_rst_in_ready", in_ready, 1);

    // Table: one isolated beat per vector
    foreach (vecs[i]) apply_one(vecs[i]);

    // Streaming at one beat per cycle, results in order
    stalls = 0;
    for (int cyc = 0; cyc < vecs.size() + 4; cyc++) begin
      @(negedge clk);
      if (cyc < vecs.size()) drive_vec(vecs[cyc]); else drive_idle();
      #1;
      if (cyc < vecs.size() && !in_ready) stalls++;
      if (out_valid) begin got_r.push_back(out_result); got_f.push_back({out_ovf, out_unf}); end
    end
    check("stream_stalls", stalls, 0);
    check("stream_count", got_r.size(), vecs.size());
    for (int i = 0; i < vecs.size() && i < got_r.size(); i++) begin
      check({"stream_", vecs[i].name}, {got_f[i], got_r[i]}, {vecs[i].ovf, vecs[i].unf, vecs[i].result});
    end

    // Backpressure: out_ready low, offer three beats back-to-back
    got_r.delete(); got_f.delete();
    idx = 0; held = '0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (idx < 3) drive_vec(vecs[idx]); else drive_idle();
      #1;
      if (cyc == 2) held = out_result;
      if (in_valid && in_ready) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_result_held", out_result, held);
    check("bp_result_first", out_result, vecs[0].result);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (idx < 3) drive_vec(vecs[idx]); else drive_idle();
      #1;
      if (out_valid) got_r.push_back(out_result);
      if (in_valid && in_ready) idx++;
    end
    check("bp_all_accepted", idx, 3);
    check("bp_delivered", got_r.size(), 3);
    for (int i = 0; i < 3 && i < got_r.size(); i++) begin
      check($sformatf("bp_order_%0d", i), got_r[i], vecs[i].result);
    end

    // Reset with both stages full discards in-flight beats
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (cyc < 2) drive_vec(vecs[3 + cyc]); else drive_idle();
    end
    #1;
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    @(negedge clk);
    rst = 1'b1; #1;
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_result", out_result, 0);
    rst = 1'b0; #1;
    check("midrst_release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk); #1;
      if (out_valid) idx++;
    end
    check("midrst_no_stale", idx, 0);
    apply_one(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_mul_round_pack.md
FP_MUL_ROUND_PACK -- requirements
Module: fp_mul_round_pack

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are listed below.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts the input beat this cycle
- in_sign  in  1  product sign (sa XOR sb)
- in_exp_sum  in  9  raw biased exponent sum ea+eb, range 0..510
- in_mant  in  48  24x24 significand product, hidden bits included
- in_zero  in  1  either operand is zero
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result this cycle
- out_result  out  32  IEEE-754 single-precision product
- out_ovf  out  1  overflow flag, result is infinity
- out_unf  out  1  underflow flag, result flushed to zero
REQ-002 The block SHALL have no parameters: bias fixed at 127, format fixed at binary32.

Function
REQ-003 SHALL be a 2-stage elastic pipeline, S1 then S2, each stage holding a valid bit.
REQ-004 An input beat SHALL transfer when in_valid && in_ready; an output beat SHALL transfer when out_valid && out_ready.
REQ-005 in_ready SHALL be !s1_valid || (s1 advances into S2 this cycle); S1 advances when !s2_valid || out_ready.
REQ-006 While out_valid=1 && out_ready=0, out_result, out_ovf and out_unf SHALL hold stable.
REQ-007 Latency SHALL be 2 cycles from input transfer to out_valid with out_ready held at 1; throughput SHALL be 1 beat per cycle.
REQ-008 S1 SHALL compute signed 11-bit e = in_exp_sum - 127.
- If in_mant[47]=1: e = e + 1; frac = in_mant[46:24]; guard = in_mant[23]; sticky = OR(in_mant[22:0]).
- Else: frac = in_mant[45:23]; guard = in_mant[22]; sticky = OR(in_mant[21:0]).
REQ-009 S2 SHALL round to nearest, ties to even: increment frac when guard && (sticky || frac[0]).
REQ-010 On rounding carry-out, S2 SHALL set frac = 0 and e = e + 1.
REQ-011 If in_zero=1, the result SHALL be {sign, 31'b0}, with ovf=0 and unf=0; in_zero overrides all other cases.
REQ-012 If final e >= 255, the result SHALL be {sign, 8'hFF, 23'b0}, with out_ovf=1.
REQ-013 If final e <= 0, the result SHALL be {sign, 31'b0}, with out_unf=1; no denormal output is produced.
REQ-014 Otherwise the result SHALL be {sign, e[7:0], frac}, with both flags 0.
REQ-015 Inputs SHALL be normal, non-NaN, non-Inf operands; in_mant[47:46]=00 with in_zero=0 is illegal, and its output is don't-care.
REQ-016 Overflow and underflow SHALL be evaluated after rounding.

Reset
REQ-017 With rst=1 at a clock edge:
- s1_valid, s2_valid and out_valid SHALL be cleared to 0.
- out_result SHALL be 0, out_ovf 0 and out_unf 0.
REQ-018 in_ready SHALL be 0 while rst=1 and SHALL be 1 on the first cycle after rst falls.
REQ-019 Reset asserted mid-operation SHALL discard in-flight beats; none appear at the output after reset.

Verification
REQ-020 in_exp_sum=255, in_mant=0x6000_0000_0000, sign 0 (1.5*2.0) -> out_result=0x40400000, flags 0, out_valid 2 cycles after acceptance.
REQ-021 in_exp_sum=254, in_mant=0x9000_0000_0000 (1.5*1.5, normalize shift) -> out_result=0x40100000.
REQ-022 in_exp_sum=254, in_mant=0x7FFF_FFC0_0000 (tie, odd LSB, rounding carry) -> out_result=0x40000000.
REQ-023 Exponent limits:
- in_exp_sum=400, in_mant=0x8000_0000_0000, sign 1 -> out_result=0xFF800000, out_ovf=1.
- in_exp_sum=100, in_mant=0x4000_0000_0000 -> out_result=0x00000000, out_unf=1.
- in_zero=1, sign 1 -> out_result=0x80000000, flags 0.
REQ-024 Backpressure:
- With out_ready=0, offer 3 beats back-to-back -> exactly 2 accepted, then in_ready=0 and out_result stable.
- Then raise out_ready -> all 3 results delivered in order, none lost or duplicated.
REQ-025 Assert rst for 1 cycle with both stages full -> out_valid=0 the next cycle; a new beat then appears 2 cycles after acceptance.
